// File: rtl/mfp_timer_regs.sv
// mfp_timer_regs: CTRL/COUNT/COMPARE/STATUS register block for a 32-bit up-counting timer with match IRQ.
// Define MFP_TIMER_PRESCALER_EN to add the 8-bit prescaler (CTRL[15:8]); default build ticks every enabled cycle.
module mfp_timer_regs #(
  parameter int unsigned ADDR_WIDTH    = 2,
  parameter logic [31:0] RESET_COMPARE = 32'hFFFFFFFF
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  read_enable,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [3:0]            write_mask,
  input  logic [31:0]           HWDATA,
  output logic [31:0]           HRDATA,
  output logic                  IRQ
);

  localparam logic [ADDR_WIDTH-1:0] A_CTRL    = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] A_COUNT   = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] A_COMPARE = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] A_STATUS  = ADDR_WIDTH'(3);

  logic        en_q, en_d;
  logic        irqen_q, irqen_d;
  logic        autoreload_q, autoreload_d;
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        match_q, match_d;
  logic [31:0] hrdata_q, hrdata_d;
`ifdef MFP_TIMER_PRESCALER_EN
  logic [7:0]  prescale_q, prescale_d;
  logic [7:0]  pcnt_q, pcnt_d;
`endif

  logic        tick;
  logic        wr_ctrl, wr_count, wr_compare, wr_status;
  logic        match_hit;
  logic        match_clr;
  logic [31:0] count_inc;
  logic [31:0] ctrl_rd;
  logic [31:0] rd_mux;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  mask);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (mask[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

  always_comb begin
    wr_ctrl    = write_enable && (write_addr == A_CTRL);
    wr_count   = write_enable && (write_addr == A_COUNT);
    wr_compare = write_enable && (write_addr == A_COMPARE);
    wr_status  = write_enable && (write_addr == A_STATUS);
  end

`ifdef MFP_TIMER_PRESCALER_EN
  always_comb begin
    tick   = en_q && (pcnt_q == prescale_q);
    pcnt_d = 8'd0;
    if (en_q && !tick) pcnt_d = pcnt_q + 8'd1;
    prescale_d = prescale_q;
    if (wr_ctrl && write_mask[1]) prescale_d = HWDATA[15:8];
    ctrl_rd = {16'd0, prescale_q, 5'd0, autoreload_q, irqen_q, en_q};
  end
`else
  always_comb begin
    tick    = en_q;
    ctrl_rd = {29'd0, autoreload_q, irqen_q, en_q};
  end
`endif

  always_comb begin
    en_d         = en_q;
    irqen_d      = irqen_q;
    autoreload_d = autoreload_q;
    if (wr_ctrl && write_mask[0]) begin
      en_d         = HWDATA[0];
      irqen_d      = HWDATA[1];
      autoreload_d = HWDATA[2];
    end

    compare_d = compare_q;
    if (wr_compare) compare_d = merge_bytes(compare_q, HWDATA, write_mask);

    // A bus write to COUNT wins over the tick for the whole register, so it also suppresses that tick's match.
    count_inc = count_q + 32'd1;
    match_hit = tick && !wr_count && (count_inc == compare_q);
    count_d   = count_q;
    if (wr_count) begin
      count_d = merge_bytes(count_q, HWDATA, write_mask);
    end else if (tick) begin
      count_d = (match_hit && autoreload_q) ? 32'd0 : count_inc;
    end

    match_clr = wr_status && write_mask[0] && HWDATA[0];
    match_d   = match_hit || (match_q && !match_clr);
  end

  always_comb begin
    rd_mux = 32'd0;
    if (read_addr == A_CTRL)    rd_mux = ctrl_rd;
    if (read_addr == A_COUNT)   rd_mux = count_q;
    if (read_addr == A_COMPARE) rd_mux = compare_q;
    if (read_addr == A_STATUS)  rd_mux = {31'd0, match_q};
    hrdata_d = read_enable ? rd_mux : hrdata_q;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      en_q         <= 1'b0;
      irqen_q      <= 1'b0;
      autoreload_q <= 1'b0;
      count_q      <= 32'd0;
      compare_q    <= RESET_COMPARE;
      match_q      <= 1'b0;
      hrdata_q     <= 32'd0;
`ifdef MFP_TIMER_PRESCALER_EN
      prescale_q   <= 8'd0;
      pcnt_q       <= 8'd0;
`endif
    end else begin
      en_q         <= en_d;
      irqen_q      <= irqen_d;
      autoreload_q <= autoreload_d;
      count_q      <= count_d;
      compare_q    <= compare_d;
      match_q      <= match_d;
      hrdata_q     <= hrdata_d;
`ifdef MFP_TIMER_PRESCALER_EN
      prescale_q   <= prescale_d;
      pcnt_q       <= pcnt_d;
`endif
    end
  end

  assign HRDATA = hrdata_q;
  assign IRQ    = match_q && irqen_q;

endmodule

// File: tb/tb_mfp_timer_regs.sv
// tb_mfp_timer_regs: directed scenarios plus randomized traffic checked against a cycle-level register model.
module tb_mfp_timer_regs;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        read_enable;
  logic [1:0]  read_addr;
  logic        write_enable;
  logic [1:0]  write_addr;
  logic [3:0]  write_mask;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        IRQ;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  bit          m_en, m_irqen, m_auto, m_match;
  logic [7:0]  m_pre, m_pcnt;
  logic [31:0] m_count, m_compare, m_hrdata;

  mfp_timer_regs dut (
    .HCLK         (HCLK),
    .HRESET       (HRESET),
    .read_enable  (read_enable),
    .read_addr    (read_addr),
    .write_enable (write_enable),
    .write_addr   (write_addr),
    .write_mask   (write_mask),
    .HWDATA       (HWDATA),
    .HRDATA       (HRDATA),
    .IRQ          (IRQ)
  );

  always #5 HCLK = ~HCLK;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [1:0] a);
    case (a)
`ifdef MFP_TIMER_PRESCALER_EN
      2'd0: return {16'd0, m_pre, 5'd0, m_auto, m_irqen, m_en};
`else
      2'd0: return {29'd0, m_auto, m_irqen, m_en};
`endif
      2'd1: return m_count;
      2'd2: return m_compare;
      default: return {31'd0, m_match};
    endcase
  endfunction

  task automatic model_step(input bit r, input bit re, input logic [1:0] ra, input bit we,
                            input logic [1:0] wa, input logic [3:0] mask, input logic [31:0] wd);
    logic [31:0] rd, new_count, new_compare;
    bit tick, new_match;
    if (r) begin
      m_en = 0; m_irqen = 0; m_auto = 0; m_match = 0;
      m_pre = 0; m_pcnt = 0; m_count = 0; m_compare = 32'hFFFFFFFF; m_hrdata = 0;
      return;
    end
    rd = model_read(ra);
`ifdef MFP_TIMER_PRESCALER_EN
    tick = m_en && (m_pcnt == m_pre);
    if (!m_en || tick) m_pcnt = 0;
    else m_pcnt = m_pcnt + 8'd1;
`else
    tick = m_en;
`endif
    new_count   = m_count;
    new_compare = m_compare;
    new_match   = m_match;
    if (we && wa == 2'd3 && mask[0] && wd[0]) new_match = 0;
    if (we && wa == 2'd1) begin
      for (int b = 0; b < 4; b++) if (mask[b]) new_count[8*b +: 8] = wd[8*b +: 8];
    end else if (tick) begin
      if (m_count + 32'd1 == m_compare) begin
        new_match = 1;
        new_count = m_auto ? 32'd0 : m_compare;
      end else begin
        new_count = m_count + 32'd1;
      end
    end
    if (we && wa == 2'd2) begin
      for (int b = 0; b < 4; b++) if (mask[b]) new_compare[8*b +: 8] = wd[8*b +: 8];
    end
    if (we && wa == 2'd0) begin
      if (mask[0]) begin m_en = wd[0]; m_irqen = wd[1]; m_auto = wd[2]; end
`ifdef MFP_TIMER_PRESCALER_EN
      if (mask[1]) m_pre = wd[15:8];
`endif
    end
    m_count = new_count;
    m_compare = new_compare;
    m_match = new_match;
    if (re) m_hrdata = rd;
  endtask

  task automatic cycle(input bit r, input bit re, input logic [1:0] ra, input bit we,
                       input logic [1:0] wa, input logic [3:0] mask, input logic [31:0] wd);
    @(negedge HCLK);
    HRESET = r; read_enable = re; read_addr = ra;
    write_enable = we; write_addr = wa; write_mask = mask; HWDATA = wd;
    @(posedge HCLK);
    model_step(r, re, ra, we, wa, mask, wd);
    #1;
    check_val("hrdata", HRDATA, m_hrdata);
    check_val("irq", {31'd0, IRQ}, {31'd0, m_match & m_irqen});
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] m);
    cycle(0, 0, 2'd0, 1, a, m, d);
  endtask

  task automatic rd(input logic [1:0] a);
    cycle(0, 1, a, 0, 2'd0, 4'h0, 32'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 2'd0, 0, 2'd0, 4'h0, 32'd0);
  endtask

  initial begin
    logic [1:0]  ra, wa;
    logic [31:0] wd;
    HRESET = 1; read_enable = 0; read_addr = 0; write_enable = 0;
    write_addr = 0; write_mask = 0; HWDATA = 0;

    cycle(1, 0, 2'd0, 0, 2'd0, 4'h0, 32'd0);
    cycle(1, 1, 2'd1, 1, 2'd1, 4'hF, 32'h55);
    check_val("reset_hrdata", HRDATA, 32'd0);
    check_val("reset_irq", {31'd0, IRQ}, 32'd0);
    rd(2'd0); check_val("reset_ctrl", HRDATA, 32'd0);
    rd(2'd1); check_val("reset_count", HRDATA, 32'd0);
    rd(2'd2); check_val("reset_compare", HRDATA, 32'hFFFFFFFF);
    rd(2'd3); check_val("reset_status", HRDATA, 32'd0);

    // Partial-lane COMPARE write, read of the same register in the write cycle sees the old value
    cycle(0, 1, 2'd2, 1, 2'd2, 4'b0100, 32'h12345678);
    check_val("rw_same_old", HRDATA, 32'hFFFFFFFF);
    rd(2'd2); check_val("compare_lane2", HRDATA, 32'hFF34FFFF);

    // Prescale 0: one count per cycle
    wr(2'd1, 32'd0, 4'hF);
    wr(2'd0, 32'h1, 4'hF);
    idle(5);
    rd(2'd1); check_val("count_5", HRDATA, 32'd5);

    // Match with autoreload, then W1C
    wr(2'd0, 32'd0, 4'hF);
    wr(2'd1, 32'd0, 4'hF);
    wr(2'd2, 32'd10, 4'hF);
    wr(2'd0, 32'h7, 4'hF);
    idle(9);
    check_val("irq_before_match", {31'd0, IRQ}, 32'd0);
    idle(1);
    check_val("irq_at_match", {31'd0, IRQ}, 32'd1);
    rd(2'd1); check_val("count_reloaded", HRDATA, 32'd0);
    rd(2'd1); check_val("count_after_reload", HRDATA, 32'd1);
    rd(2'd3); check_val("status_match", HRDATA, 32'd1);
    wr(2'd3, 32'd1, 4'h1);
    check_val("irq_cleared", {31'd0, IRQ}, 32'd0);

    // Wrap past all-ones without a match
    wr(2'd0, 32'd0, 4'hF);
    wr(2'd1, 32'hFFFFFFFE, 4'hF);
    wr(2'd2, 32'd5, 4'hF);
    wr(2'd3, 32'd1, 4'h1);
    wr(2'd0, 32'h1, 4'hF);
    rd(2'd1); check_val("wrap_fe", HRDATA, 32'hFFFFFFFE);
    rd(2'd1); check_val("wrap_ff", HRDATA, 32'hFFFFFFFF);
    rd(2'd1); check_val("wrap_0", HRDATA, 32'd0);
    rd(2'd3); check_val("wrap_no_match", HRDATA, 32'd0);

    // Reset mid-count with MATCH set
    wr(2'd0, 32'd0, 4'hF);
    wr(2'd2, 32'd3, 4'hF);
    wr(2'd1, 32'd0, 4'hF);
    wr(2'd3, 32'd1, 4'h1);
    wr(2'd0, 32'h3, 4'hF);
    idle(3);
    check_val("irq_pre_reset", {31'd0, IRQ}, 32'd1);
    idle(2);
    cycle(1, 1, 2'd1, 1, 2'd1, 4'hF, 32'h77);
    check_val("midreset_hrdata", HRDATA, 32'd0);
    check_val("midreset_irq", {31'd0, IRQ}, 32'd0);
    rd(2'd0); check_val("midreset_ctrl", HRDATA, 32'd0);
    rd(2'd1); check_val("midreset_count", HRDATA, 32'd0);
    rd(2'd2); check_val("midreset_compare", HRDATA, 32'hFFFFFFFF);
    rd(2'd3); check_val("midreset_status", HRDATA, 32'd0);

`ifdef MFP_TIMER_PRESCALER_EN
    wr(2'd0, 32'h301, 4'hF);
    idle(16);
    rd(2'd1); check_val("prescale3_count", HRDATA, 32'd4);
    wr(2'd0, 32'd0, 4'hF);
`else
    wr(2'd0, 32'hFF01, 4'hF);
    rd(2'd0); check_val("ctrl_no_prescale", HRDATA, 32'h1);
    wr(2'd0, 32'd0, 4'hF);
`endif

    for (int i = 0; i < 3000; i++) begin
      ra = 2'($urandom_range(0, 3));
      wa = 2'($urandom_range(0, 3));
      case (wa)
        2'd0: begin
          wd = $urandom;
          wd[0] = ($urandom_range(0, 3) != 0);
          wd[15:8] = 8'($urandom_range(0, 3));
        end
        2'd1, 2'd2: wd = ($urandom_range(0, 7) == 0) ? $urandom : $urandom_range(0, 20);
        default: wd = $urandom;
      endcase
      cycle($urandom_range(0, 199) == 0, $urandom_range(0, 1) == 1, ra,
            $urandom_range(0, 2) == 0, wa, 4'($urandom_range(1, 15)), wd);
      if ($urandom_range(0, 3) == 0) begin
        rd(2'($urandom_range(0, 3)));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mfp_timer_regs.md
MFP_TIMER_REGS -- requirements
Module: mfp_timer_regs

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 2, meaning word-index width of read_addr/write_addr (4 registers).
REQ-002 SHALL have parameter RESET_COMPARE, default 32'hFFFFFFFF, meaning reset value of COMPARE.
REQ-003 SHALL have port HCLK  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port HRESET  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port read_enable  input  1  read strobe from the upstream AHB-Lite slave adapter.
REQ-006 SHALL have port read_addr  input  ADDR_WIDTH  word index of the read.
REQ-007 SHALL have port write_enable  input  1  write strobe from the adapter, aligned with HWDATA.
REQ-008 SHALL have port write_addr  input  ADDR_WIDTH  word index of the write.
REQ-009 SHALL have port write_mask  input  4  byte-lane enables; bit n covers HWDATA[8n+7:8n].
REQ-010 SHALL have port HWDATA  input  32  write data.
REQ-011 SHALL have port HRDATA  output  32  registered read data.
REQ-012 SHALL have port IRQ  output  1  interrupt, level, = STATUS.MATCH & CTRL.IRQEN.

Function
REQ-013 SHALL decode registers: 0 CTRL, 1 COUNT, 2 COMPARE, 3 STATUS.
REQ-014 SHALL define CTRL: bit0 EN, bit1 IRQEN, bit2 AUTORELOAD, bits15:8 PRESCALE; other bits read 0, ignore writes.
REQ-015 SHALL define STATUS: bit0 MATCH; writing 1 with lane 0 enabled clears it; writing 0 has no effect; other bits read 0.
REQ-016 SHALL apply writes only to byte lanes with write_mask bit set, in the cycle write_enable is high.
REQ-017 SHALL load HRDATA on the clock edge ending a cycle with read_enable high, with the register value before that edge's updates; HRDATA holds otherwise (1-cycle read latency).
REQ-018 SHALL generate a tick when EN=1 and the 8-bit prescale counter equals PRESCALE; prescale counter then returns to 0, else increments; held at 0 while EN=0.
REQ-019 SHALL increment COUNT by 1 on each tick, wrapping 32'hFFFFFFFF to 0 without setting MATCH unless COMPARE matches.
REQ-020 SHALL set MATCH on a tick where the incremented COUNT value equals COMPARE.
REQ-021 SHALL, when AUTORELOAD=1, load COUNT with 0 instead of COMPARE on the matching tick (MATCH still set).
REQ-022 SHALL give a same-cycle COUNT write priority over tick increment/reload, per written byte, unwritten bytes keeping the pre-write value; no MATCH from that tick.
REQ-023 SHALL give MATCH set priority over a simultaneous W1C clear.
REQ-024 SHALL treat simultaneous read and write of the same register per REQ-017 (old value returned).

Reset
REQ-025 SHALL on HRESET=1 set CTRL=0, COUNT=0, COMPARE=RESET_COMPARE, MATCH=0, prescale counter=0, HRDATA=0; IRQ=0 follows.
REQ-026 SHALL abort any in-progress prescale/count activity on reset mid-operation and ignore read_enable/write_enable during reset.

Configuration
REQ-027 SHALL, with MFP_TIMER_PRESCALER_EN defined, implement PRESCALE per REQ-018.
REQ-028 SHALL, without MFP_TIMER_PRESCALER_EN, omit the prescale counter, tick every cycle with EN=1, and read CTRL[15:8] as 0 ignoring writes.

Verification
REQ-029 SHALL cover: write CTRL=32'h00000001 (PRESCALE 0), COUNT=0 -> COUNT reads 5 after 5 further cycles.
REQ-030 SHALL cover: PRESCALE=3, EN=1 for 16 cycles -> COUNT=4 (prescaler build only).
REQ-031 SHALL cover: COMPARE=10, CTRL=32'h7 -> MATCH and IRQ assert on tick 10, COUNT reads 0, then increments again; W1C STATUS=1 -> IRQ low next cycle.
REQ-032 SHALL cover: COUNT=32'hFFFFFFFE, COMPARE=5, EN=1 -> COUNT wraps 32'hFFFFFFFF to 0, MATCH stays 0.
REQ-033 SHALL cover: write COMPARE=32'h12345678 with write_mask=4'b0100 -> COMPARE reads 32'hFF34FFFF from reset value; read of same register in write cycle returns 32'hFFFFFFFF.
REQ-034 SHALL cover: HRESET asserted mid-count with MATCH=1 -> all registers at reset values, IRQ=0, next cycle after release.
